// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter slice.
package regfile_wb_pkg;

  localparam int NUM_REGS = 32;

  typedef logic [4:0]  regbits_t;
  typedef logic [31:0] word_t;

  typedef enum logic {
    WB_PIPE = 1'b0,
    WB_LU   = 1'b1
  } wb_src_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy scoreboard: one bit per architectural register marking an outstanding
// long-latency result. Register 0 is never busy. A set and a clear of the same
// bit on the same edge resolves to set, so a newer issue to the same
// destination is not lost when an older result commits.
module reg_scoreboard
  import regfile_wb_pkg::*;
(
  input  logic     CLK,
  input  logic     RST,
  input  logic     set_en,
  input  regbits_t set_sel,
  input  logic     clr_en,
  input  regbits_t clr_sel,
  input  regbits_t rs_sel,
  input  regbits_t rt_sel,
  output logic     rs_busy,
  output logic     rt_busy
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  logic [NUM_REGS-1:0] w_busy_nxt;

  // Decode set/clear requests into one-hot masks; set overrides clear, bit 0 pinned low.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (set_en) w_set[set_sel] = 1'b1;
    if (clr_en) w_clr[clr_sel] = 1'b1;
    w_busy_nxt    = (r_busy & ~w_clr) | w_set;
    w_busy_nxt[0] = 1'b0;
  end

  // Busy vector state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  assign rs_busy = r_busy[rs_sel];
  assign rt_busy = r_busy[rt_sel];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: pipeline writeback (source 0) normally wins;
// the long-latency unit (source 1) is accepted when the pipeline is idle.
// Optional anti-starvation guard, enabled by defining WB_STARVE_GUARD_EN:
// after STARVE_MAX cycles of waiting, source 1 preempts source 0.
// The winning write is registered onto rf_*; a busy scoreboard tracks
// outstanding long-latency destinations.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic     CLK,
  input  logic     RST,
  input  logic     pipe_valid,
  input  regbits_t pipe_wsel,
  input  word_t    pipe_wdat,
  output logic     pipe_ready,
  input  logic     lu_valid,
  input  regbits_t lu_wsel,
  input  word_t    lu_wdat,
  output logic     lu_ready,
  input  logic     lu_issue,
  input  regbits_t lu_issue_rd,
  input  regbits_t rs_sel,
  input  regbits_t rt_sel,
  output logic     rs_busy,
  output logic     rt_busy,
  output logic     rf_WEN,
  output regbits_t rf_wsel,
  output word_t    rf_wdat,
  output wb_src_t  rf_src
);

  logic     w_starved;
  logic     w_accept;
  regbits_t w_wsel;
  word_t    w_wdat;
  wb_src_t  w_src;

`ifdef WB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] r_wait_cnt;

  assign w_starved = lu_valid && (r_wait_cnt == CNT_MAX);

  // Count cycles source 1 waits with valid high; clear on acceptance or idle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                       r_wait_cnt <= '0;
    else if (!lu_valid || lu_ready) r_wait_cnt <= '0;
    else if (r_wait_cnt != CNT_MAX) r_wait_cnt <= r_wait_cnt + 1'b1;
  end
`else
  logic w_unused_starve;
  assign w_unused_starve = (STARVE_MAX == 0);
  assign w_starved       = 1'b0;
`endif

  // Grant one source per cycle and select the winning write.
  always_comb begin
    pipe_ready = pipe_valid && !w_starved;
    lu_ready   = lu_valid && (!pipe_valid || w_starved);
    w_accept   = pipe_ready || lu_ready;
    w_wsel     = pipe_wsel;
    w_wdat     = pipe_wdat;
    w_src      = WB_PIPE;
    if (lu_ready) begin
      w_wsel = lu_wsel;
      w_wdat = lu_wdat;
      w_src  = WB_LU;
    end
  end

  // Register the accepted write; writes to register 0 are consumed without enable.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rf_WEN  <= 1'b0;
      rf_wsel <= '0;
      rf_wdat <= '0;
      rf_src  <= WB_PIPE;
    end else if (w_accept) begin
      rf_WEN  <= (w_wsel != '0);
      rf_wsel <= w_wsel;
      rf_wdat <= w_wdat;
      rf_src  <= w_src;
    end else begin
      rf_WEN  <= 1'b0;
    end
  end

  reg_scoreboard u_scoreboard (
    .CLK     (CLK),
    .RST     (RST),
    .set_en  (lu_issue),
    .set_sel (lu_issue_rd),
    .clr_en  (rf_WEN && (rf_src == WB_LU)),
    .clr_sel (rf_wsel),
    .rs_sel  (rs_sel),
    .rt_sel  (rt_sel),
    .rs_busy (rs_busy),
    .rt_busy (rt_busy)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;
  import regfile_wb_pkg::*;

  logic     CLK = 1'b0;
  logic     RST;
  logic     pipe_valid, lu_valid, lu_issue;
  regbits_t pipe_wsel, lu_wsel, lu_issue_rd, rs_sel, rt_sel;
  word_t    pipe_wdat, lu_wdat;
  logic     pipe_ready, lu_ready, rs_busy, rt_busy, rf_WEN;
  regbits_t rf_wsel;
  word_t    rf_wdat;
  wb_src_t  rf_src;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  regfile_wb_arbiter #(.STARVE_MAX(4)) dut (
    .CLK(CLK), .RST(RST),
    .pipe_valid(pipe_valid), .pipe_wsel(pipe_wsel), .pipe_wdat(pipe_wdat), .pipe_ready(pipe_ready),
    .lu_valid(lu_valid), .lu_wsel(lu_wsel), .lu_wdat(lu_wdat), .lu_ready(lu_ready),
    .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd),
    .rs_sel(rs_sel), .rt_sel(rt_sel), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .rf_WEN(rf_WEN), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat), .rf_src(rf_src)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    pipe_valid = 0; pipe_wsel = '0; pipe_wdat = '0;
    lu_valid = 0; lu_wsel = '0; lu_wdat = '0;
    lu_issue = 0; lu_issue_rd = '0; rs_sel = '0; rt_sel = '0;
    tick(); tick();
    chk("rst_wen",  rf_WEN, 0);
    chk("rst_wsel", rf_wsel, 0);
    chk("rst_wdat", rf_wdat, 0);
    chk("rst_src",  rf_src, 0);
    RST = 1'b0;
    tick();

    // single pipeline write
    pipe_valid = 1; pipe_wsel = 5'd3; pipe_wdat = 32'hDEADBEEF;
    #1;
    chk("pipe_rdy", pipe_ready, 1);
    chk("pipe_lurdy", lu_ready, 0);
    tick();
    pipe_valid = 0;
    chk("pipe_wen",  rf_WEN, 1);
    chk("pipe_wsel", rf_wsel, 3);
    chk("pipe_wdat", rf_wdat, 32'hDEADBEEF);
    chk("pipe_src",  rf_src, 0);
    tick();
    chk("idle_wen",  rf_WEN, 0);
    chk("hold_wsel", rf_wsel, 3);
    chk("hold_wdat", rf_wdat, 32'hDEADBEEF);

    // scoreboard set and clear through lu commit
    lu_issue = 1; lu_issue_rd = 5'd9; rs_sel = 5'd9; rt_sel = 5'd9;
    tick();
    lu_issue = 0;
    chk("sb_rs_set", rs_busy, 1);
    chk("sb_rt_set", rt_busy, 1);
    rt_sel = 5'd8;
    #1;
    chk("sb_rt_other", rt_busy, 0);
    lu_valid = 1; lu_wsel = 5'd9; lu_wdat = 32'h0000_1234;
    #1;
    chk("lu_rdy", lu_ready, 1);
    tick();
    lu_valid = 0;
    chk("lu_wen",  rf_WEN, 1);
    chk("lu_wsel", rf_wsel, 9);
    chk("lu_wdat", rf_wdat, 32'h0000_1234);
    chk("lu_src",  rf_src, 1);
    chk("sb_busy_n1", rs_busy, 1);
    tick();
    chk("sb_clr_n2", rs_busy, 0);
    chk("lu_wen_off", rf_WEN, 0);

    // same-edge set and clear: set wins
    lu_issue = 1; lu_issue_rd = 5'd9;
    tick();
    lu_issue = 0;
    lu_valid = 1; lu_wsel = 5'd9; lu_wdat = 32'h0000_0099;
    tick();
    lu_valid = 0;
    lu_issue = 1; lu_issue_rd = 5'd9;
    chk("same_wen", rf_WEN, 1);
    tick();
    lu_issue = 0;
    chk("same_busy", rs_busy, 1);
    lu_valid = 1; lu_wsel = 5'd9; lu_wdat = 32'h0000_0100;
    tick();
    lu_valid = 0;
    tick();
    chk("same_clr", rs_busy, 0);

    // register 0
    lu_valid = 1; lu_wsel = 5'd0; lu_wdat = 32'hFFFF_FFFF;
    #1;
    chk("r0_rdy", lu_ready, 1);
    tick();
    lu_valid = 0;
    chk("r0_wen", rf_WEN, 0);
    lu_issue = 1; lu_issue_rd = 5'd0; rs_sel = 5'd0;
    tick();
    lu_issue = 0;
    chk("r0_busy", rs_busy, 0);

    // both sources valid continuously
    pipe_valid = 1; pipe_wsel = 5'd4; pipe_wdat = 32'hAAAA_0004;
    lu_valid = 1; lu_wsel = 5'd7; lu_wdat = 32'hBBBB_0007;
`ifdef WB_STARVE_GUARD_EN
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("starve_prdy_c%0d", c), pipe_ready, (c < 5) ? 1 : 0);
      chk($sformatf("starve_lrdy_c%0d", c), lu_ready,   (c < 5) ? 0 : 1);
      tick();
    end
    lu_valid = 0;
    #1;
    chk("starve_after_prdy", pipe_ready, 1);
    chk("starve_wen",  rf_WEN, 1);
    chk("starve_src",  rf_src, 1);
    chk("starve_wsel", rf_wsel, 7);
    chk("starve_wdat", rf_wdat, 32'hBBBB_0007);
    lu_valid = 1;
    #1;
    chk("starve_cnt_clr", lu_ready, 0);
    lu_valid = 0;
`else
    for (int c = 1; c <= 8; c++) begin
      #1;
      chk($sformatf("fixed_prdy_c%0d", c), pipe_ready, 1);
      chk($sformatf("fixed_lrdy_c%0d", c), lu_ready, 0);
      tick();
    end
    chk("fixed_src", rf_src, 0);
    pipe_valid = 0;
    #1;
    chk("fixed_lu_free", lu_ready, 1);
    lu_valid = 0;
`endif
    pipe_valid = 0;
    tick();
    tick();

    // reset mid-write with busy[5] set
    lu_issue = 1; lu_issue_rd = 5'd5; rs_sel = 5'd5;
    tick();
    lu_issue = 0;
    pipe_valid = 1; pipe_wsel = 5'd6; pipe_wdat = 32'h0000_0066;
    tick();
    pipe_valid = 0;
    chk("prerst_wen",  rf_WEN, 1);
    chk("prerst_busy", rs_busy, 1);
    RST = 1'b1;
    #1;
    chk("rst_mid_wen",  rf_WEN, 0);
    chk("rst_mid_busy", rs_busy, 0);
    tick();
    RST = 1'b0;
    tick();
    chk("postrst_wen", rf_WEN, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single register-file write port between two writeback sources:
- the in-order pipeline writeback stage (source 0);
- the long-latency unit (multiply/divide, source 1).

The block registers the winning write onto the port that drives the register file's write-enable decoder. It also keeps a 32-entry busy scoreboard of registers that have outstanding long-latency results, so hazard logic can stall dependent instructions.

## Interface
Parameters:
- STARVE_MAX, 4, cycles source 1 may wait with valid asserted before it preempts source 0; minimum 1.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- pipe_valid  input  1  source 0 has a write.
- pipe_wsel  input  5  source 0 destination register.
- pipe_wdat  input  32  source 0 data.
- pipe_ready  output  1  source 0 write accepted this cycle (combinational).
- lu_valid  input  1  source 1 has a write.
- lu_wsel  input  5  source 1 destination register.
- lu_wdat  input  32  source 1 data.
- lu_ready  output  1  source 1 write accepted this cycle (combinational).
- lu_issue  input  1  an instruction dispatched to the long-latency unit this cycle.
- lu_issue_rd  input  5  destination of that instruction.
- rs_sel, rt_sel  input  5 each  scoreboard query indexes.
- rs_busy, rt_busy  output  1 each  queried register has a pending long-latency write (combinational from state).
- rf_WEN  output  1  register-file write enable (registered).
- rf_wsel  output  5  register-file write select (registered).
- rf_wdat  output  32  register-file write data (registered).
- rf_src  output  1  source of the current rf_* write; 0 = pipe, 1 = lu (registered).

## Operation
Arbitration (one acceptance per cycle):
- Default: source 0 has priority. pipe_ready = pipe_valid.
- lu_ready = lu_valid && !pipe_valid.
- Starved: the wait counter equals STARVE_MAX and lu_valid is high. Then lu_ready = 1 and pipe_ready = 0.

Wait counter:
- Increments each cycle that lu_valid && !lu_ready, saturating at STARVE_MAX.
- Clears on an lu acceptance, or when lu_valid is low.
- Width is clog2(STARVE_MAX+1).

Write port:
- An accepted write is registered into rf_WEN/rf_wsel/rf_wdat/rf_src on the next edge.
- An accepted write to register 0 is consumed (ready is asserted) but produces rf_WEN = 0.
- With no acceptance, rf_WEN = 0. rf_wsel, rf_wdat and rf_src hold their previous values.

Scoreboard:
- busy[r] is set on an edge with lu_issue && lu_issue_rd == r, for r != 0.
- busy[r] is cleared on the edge ending a cycle where rf_WEN && rf_src && rf_wsel == r, i.e. when the register file actually commits the write.
- If a set and a clear for the same r fall on the same edge, set wins. This covers a newer issue overwriting the same destination.
- busy[0] is always 0.
- Pipeline writes never touch the scoreboard.

Reset (while RST is high):
- rf_WEN = 0, rf_wsel = 0, rf_wdat = 0, rf_src = 0.
- Wait counter = 0 and all busy bits = 0.
- A write in flight is dropped, and a pending long-latency result's busy bit is lost.
- The pipeline flush associated with reset is the owner's responsibility.

## Timing
- Latency: acceptance in cycle N puts rf_WEN high in cycle N+1. The register file writes at the end of cycle N+1.
- For a source 1 write, busy[rd] is low from cycle N+2.
- Ready signals are combinational from the valid inputs and the counter state. A source holds valid/wsel/wdat until it sees ready.
- Worst-case wait for source 1 under continuous pipe traffic is STARVE_MAX cycles, and it is accepted in cycle STARVE_MAX+1.
- Throughput: one write per cycle, with no bubbles between back-to-back acceptances.

## Configuration
- WB_STARVE_GUARD_EN defined: the starvation counter and preemption operate as described.
- WB_STARVE_GUARD_EN undefined:
  - The counter is not built and STARVE_MAX is ignored.
  - Fixed priority applies: lu_ready = lu_valid && !pipe_valid, and pipe_ready = pipe_valid always.

## Structure
- Shared package regfile_wb_pkg provides:
  - regbits_t (5-bit register index) and word_t (32-bit);
  - wb_src_t enum {WB_PIPE = 0, WB_LU = 1}, used for rf_src;
  - constant NUM_REGS = 32.
- Sub-module reg_scoreboard holds the busy vector, the set/clear logic and the two query read ports. The top level contains the arbiter, the counter and the output register.

## Test plan
- Reset: assert RST mid-write with busy[5] set -> rf_WEN = 0 and rs_busy (rs_sel = 5) = 0 immediately. After release there is no write for 1 cycle.
- Single source: pipe_valid with wsel = 3, wdat = 0xDEADBEEF -> pipe_ready = 1, then the next cycle shows rf_WEN = 1, rf_wsel = 3, rf_wdat = 0xDEADBEEF, rf_src = 0.
- Conflict with guard: both valid continuously, STARVE_MAX = 4 -> pipe wins for 4 cycles, then lu_ready = 1 with pipe_ready = 0 in the 5th cycle, then the counter clears. Without WB_STARVE_GUARD_EN, lu is never accepted while pipe_valid is high.
- Scoreboard: lu_issue with rd = 9 -> rs_busy = 1 (rs_sel = 9). The lu write to 9 is accepted in cycle N, rf_WEN is high in N+1, and rs_busy = 0 in N+2.
- Same-edge set/clear: lu commit to 9 coincides with lu_issue rd = 9 -> busy[9] stays 1.
- Register 0: lu write with wsel = 0 -> lu_ready = 1 and rf_WEN = 0 next cycle. lu_issue with rd = 0 -> busy[0] stays 0.
